// File: rtl/sonar_serial_rx.sv
// Serial telemetry receiver for the sonar link: 7E1 characters, "AAA,DDD#" frames decoded to BCD.
// Optional macro SONAR_RX_PARIDADE_EN enables even-parity checking (otherwise the parity bit is ignored).
module sonar_serial_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = 217
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] angulo,
    output logic [11:0] distancia,
    output logic        frame_valido,
    output logic        erro_paridade,
    output logic        erro_formato,
    output logic [3:0]  db_estado
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [6:0] CH_VIRG = 7'h2C;
    localparam logic [6:0] CH_HASH = 7'h23;

    typedef enum logic [2:0] {OCIOSO, INICIO, DADOS, PARIDADE, PARADA} bit_state_t;
    typedef enum logic [3:0] {
        P_A0 = 4'd0, P_A1 = 4'd1, P_A2 = 4'd2, P_VIRG = 4'd3,
        P_D0 = 4'd4, P_D1 = 4'd5, P_D2 = 4'd6, P_HASH = 4'd7
    } p_state_t;

    logic             sync1_q, sync2_q, rx_prev_q;
    bit_state_t       bit_state_q, bit_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [6:0]       shift_q, shift_d;
    p_state_t         p_state_q, p_state_d;
    logic [11:0]      ang_sh_q, ang_sh_d, dist_sh_q, dist_sh_d;
    logic [11:0]      ang_q, ang_d, dist_q, dist_d;
    logic             frame_valido_q, frame_valido_d;
    logic             erro_formato_q, erro_formato_d;
    logic             byte_ok, bad, is_digit;
    logic             rx_s;
`ifdef SONAR_RX_PARIDADE_EN
    logic             par_q, par_d;
    logic             erro_paridade_q, erro_paridade_d;
`endif

    assign rx_s     = sync2_q;
    assign is_digit = (shift_q[6:4] == 3'b011) && (shift_q[3:0] <= 4'd9);

    always_comb begin
        bit_state_d    = bit_state_q;
        cnt_d          = cnt_q;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        p_state_d      = p_state_q;
        ang_sh_d       = ang_sh_q;
        dist_sh_d      = dist_sh_q;
        ang_d          = ang_q;
        dist_d         = dist_q;
        frame_valido_d = 1'b0;
        erro_formato_d = 1'b0;
        byte_ok        = 1'b0;
        bad            = 1'b0;
`ifdef SONAR_RX_PARIDADE_EN
        par_d           = par_q;
        erro_paridade_d = 1'b0;
`endif

        case (bit_state_q)
            OCIOSO: begin
                if (rx_prev_q && !rx_s) begin
                    bit_state_d = INICIO;
                    cnt_d       = '0;
                end
            end
            INICIO: begin
                if (cnt_q == HALF_END) begin
                    cnt_d       = '0;
                    bit_idx_d   = '0;
                    // A line already back high at mid start bit was a glitch.
                    bit_state_d = rx_s ? OCIOSO : DADOS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DADOS: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[6:1]};
                    if (bit_idx_q == 3'd6) bit_state_d = PARIDADE;
                    else                   bit_idx_d   = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARIDADE: begin
                if (cnt_q == BIT_END) begin
                    cnt_d       = '0;
`ifdef SONAR_RX_PARIDADE_EN
                    par_d       = rx_s;
`endif
                    bit_state_d = PARADA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARADA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d       = '0;
                    bit_state_d = OCIOSO;
                    if (!rx_s) begin
                        erro_formato_d = 1'b1;
                        p_state_d      = P_A0;
                    end
`ifdef SONAR_RX_PARIDADE_EN
                    else if (^{shift_q, par_q}) begin
                        erro_paridade_d = 1'b1;
                        p_state_d       = P_A0;
                    end
`endif
                    else begin
                        byte_ok = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: bit_state_d = OCIOSO;
        endcase

        if (byte_ok) begin
            case (p_state_q)
                P_A0: if (is_digit) begin ang_sh_d[11:8]  = shift_q[3:0]; p_state_d = P_A1; end else bad = 1'b1;
                P_A1: if (is_digit) begin ang_sh_d[7:4]   = shift_q[3:0]; p_state_d = P_A2; end else bad = 1'b1;
                P_A2: if (is_digit) begin ang_sh_d[3:0]   = shift_q[3:0]; p_state_d = P_VIRG; end else bad = 1'b1;
                P_VIRG: if (shift_q == CH_VIRG) p_state_d = P_D0; else bad = 1'b1;
                P_D0: if (is_digit) begin dist_sh_d[11:8] = shift_q[3:0]; p_state_d = P_D1; end else bad = 1'b1;
                P_D1: if (is_digit) begin dist_sh_d[7:4]  = shift_q[3:0]; p_state_d = P_D2; end else bad = 1'b1;
                P_D2: if (is_digit) begin dist_sh_d[3:0]  = shift_q[3:0]; p_state_d = P_HASH; end else bad = 1'b1;
                P_HASH: begin
                    if (shift_q == CH_HASH) begin
                        ang_d          = ang_sh_q;
                        dist_d         = dist_sh_q;
                        frame_valido_d = 1'b1;
                        p_state_d      = P_A0;
                    end else begin
                        bad = 1'b1;
                    end
                end
                default: bad = 1'b1;
            endcase
            // A stray '#' just realigns to the next frame without flagging an error.
            if (bad) begin
                p_state_d = P_A0;
                if (shift_q != CH_HASH) erro_formato_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            rx_prev_q      <= 1'b1;
            bit_state_q    <= OCIOSO;
            cnt_q          <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            p_state_q      <= P_A0;
            ang_sh_q       <= '0;
            dist_sh_q      <= '0;
            ang_q          <= '0;
            dist_q         <= '0;
            frame_valido_q <= 1'b0;
            erro_formato_q <= 1'b0;
        end else begin
            sync1_q        <= entrada_serial;
            sync2_q        <= sync1_q;
            rx_prev_q      <= sync2_q;
            bit_state_q    <= bit_state_d;
            cnt_q          <= cnt_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            p_state_q      <= p_state_d;
            ang_sh_q       <= ang_sh_d;
            dist_sh_q      <= dist_sh_d;
            ang_q          <= ang_d;
            dist_q         <= dist_d;
            frame_valido_q <= frame_valido_d;
            erro_formato_q <= erro_formato_d;
        end
    end

`ifdef SONAR_RX_PARIDADE_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            par_q           <= 1'b0;
            erro_paridade_q <= 1'b0;
        end else begin
            par_q           <= par_d;
            erro_paridade_q <= erro_paridade_d;
        end
    end
    assign erro_paridade = erro_paridade_q;
`else
    assign erro_paridade = 1'b0;
`endif

    assign angulo       = ang_q;
    assign distancia    = dist_q;
    assign frame_valido = frame_valido_q;
    assign erro_formato = erro_formato_q;
    assign db_estado    = p_state_q;

endmodule

// File: tb/tb_sonar_serial_rx.sv
// Directed bench for sonar_serial_rx using a shortened bit time to keep runs short.
module tb_sonar_serial_rx;

    localparam int C = 40;
    localparam int H = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        entrada_serial = 1'b1;
    logic [11:0] angulo, distancia;
    logic        frame_valido, erro_paridade, erro_formato;
    logic [3:0]  db_estado;

    int n_cmp = 0, n_err = 0;
    int fv_cnt = 0, ep_cnt = 0, ef_cnt = 0, ov_cnt = 0;
    int fv0, ep0, ef0;
`ifdef SONAR_RX_PARIDADE_EN
    localparam int EXP_EP = 1;
`else
    localparam int EXP_EP = 0;
`endif

    sonar_serial_rx #(.CLKS_PER_BIT(C), .HALF_BIT(H)) dut (
        .clock(clock), .reset(reset), .entrada_serial(entrada_serial),
        .angulo(angulo), .distancia(distancia), .frame_valido(frame_valido),
        .erro_paridade(erro_paridade), .erro_formato(erro_formato), .db_estado(db_estado)
    );

    always #10 clock = ~clock;

    always @(negedge clock) begin
        if (frame_valido)  fv_cnt++;
        if (erro_paridade) ep_cnt++;
        if (erro_formato)  ef_cnt++;
        if (int'(frame_valido) + int'(erro_paridade) + int'(erro_formato) > 1) ov_cnt++;
    end

    task automatic send_byte(input logic [6:0] b, input bit flip);
        logic par;
        par = (^b) ^ flip;
        @(negedge clock); entrada_serial = 1'b0;
        repeat (C) @(negedge clock);
        for (int i = 0; i < 7; i++) begin
            entrada_serial = b[i];
            repeat (C) @(negedge clock);
        end
        entrada_serial = par;
        repeat (C) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (3 * C) @(negedge clock);
    endtask

    task automatic send_str(input string s);
        logic [7:0] ch;
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            send_byte(ch[6:0], 1'b0);
        end
    endtask

    task automatic snap();
        fv0 = fv_cnt; ep0 = ep_cnt; ef0 = ef_cnt;
    endtask

    task automatic check_frame(input string nm, input logic [11:0] ea, input logic [11:0] ed,
                               input int efv, input int eep, input int eef);
        n_cmp++; if (fv_cnt - fv0 !== efv) begin n_err++; $display("FAIL %s frame_valido pulses got %0d exp %0d", nm, fv_cnt - fv0, efv); end
        n_cmp++; if (ep_cnt - ep0 !== eep) begin n_err++; $display("FAIL %s erro_paridade pulses got %0d exp %0d", nm, ep_cnt - ep0, eep); end
        n_cmp++; if (ef_cnt - ef0 !== eef) begin n_err++; $display("FAIL %s erro_formato pulses got %0d exp %0d", nm, ef_cnt - ef0, eef); end
        n_cmp++; if (angulo !== ea) begin n_err++; $display("FAIL %s angulo got %h exp %h", nm, angulo, ea); end
        n_cmp++; if (distancia !== ed) begin n_err++; $display("FAIL %s distancia got %h exp %h", nm, distancia, ed); end
        n_cmp++; if (db_estado !== 4'd0) begin n_err++; $display("FAIL %s db_estado got %0d exp 0", nm, db_estado); end
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clock);
        n_cmp++; if ({angulo, distancia, frame_valido, erro_paridade, erro_formato, db_estado} !== 31'd0) begin
            n_err++; $display("FAIL reset_outputs got %h exp 0", {angulo, distancia, frame_valido, erro_paridade, erro_formato, db_estado});
        end
        reset = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_basic();
        snap();
        send_str("090,");
        n_cmp++; if (db_estado !== 4'd4) begin n_err++; $display("FAIL basic_midstate db_estado got %0d exp 4", db_estado); end
        send_str("123#");
        check_frame("basic", 12'h090, 12'h123, 1, 0, 0);
    endtask

    task automatic test_parity();
        snap();
        send_str("045,0");
        send_byte(7'h23, 1'b1);
        send_str("045,020#");
        check_frame("parity", 12'h045, 12'h020, 1, EXP_EP, 0);
    endtask

    task automatic test_format();
        snap();
        // 'A' breaks the angle, then ',' in P_A0 is also bad; "123#" ends in a silent resync.
        send_str("09A,123#");
        check_frame("format", 12'h045, 12'h020, 0, 0, 2);
        snap();
        send_str("180,999#");
        check_frame("format_recover", 12'h180, 12'h999, 1, 0, 0);
    endtask

    task automatic test_glitch();
        snap();
        @(negedge clock); entrada_serial = 1'b0;
        repeat (10) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (3 * C) @(negedge clock);
        check_frame("glitch_idle", 12'h180, 12'h999, 0, 0, 0);
        snap();
        send_str("000,001#");
        check_frame("glitch_frame", 12'h000, 12'h001, 1, 0, 0);
    endtask

    task automatic test_resync();
        snap();
        send_str("12");
        n_cmp++; if (db_estado !== 4'd2) begin n_err++; $display("FAIL resync_midstate db_estado got %0d exp 2", db_estado); end
        send_str("#");
        check_frame("resync_hash", 12'h000, 12'h001, 0, 0, 0);
        snap();
        send_str("135,777#");
        check_frame("resync_frame", 12'h135, 12'h777, 1, 0, 0);
    endtask

    task automatic test_mid_reset();
        logic [6:0] b;
        b = 7'h37;
        send_str("246,");
        @(negedge clock); entrada_serial = 1'b0;
        repeat (C) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            entrada_serial = b[i];
            repeat (C) @(negedge clock);
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++; if ({angulo, distancia, frame_valido, erro_paridade, erro_formato, db_estado} !== 31'd0) begin
            n_err++; $display("FAIL midreset_outputs got %h exp 0", {angulo, distancia, frame_valido, erro_paridade, erro_formato, db_estado});
        end
        entrada_serial = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3 * C) @(negedge clock);
        snap();
        send_str("030,456#");
        check_frame("midreset_frame", 12'h030, 12'h456, 1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_format();
        test_glitch();
        test_resync();
        test_mid_reset();
        n_cmp++; if (ov_cnt !== 0) begin n_err++; $display("FAIL pulse_exclusive overlaps got %0d exp 0", ov_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
